instr_prefetch: RTL and testbench

- Parametrised instruction fetch unit between the CPU fetch stage and the memory bus master.
- Streams sequential instruction words into a DEPTH-entry prefetch FIFO ahead of the CPU, so a sequential fetch completes in one cycle when the word is already buffered.
- Handles redirects (clear), stalls (hold), and a bus transaction that is still in flight when a flush occurs.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/prefetch_fifo.sv | 68 ++++++
 rtl/instr_prefetch.sv | 133 +++++++++++++
 tb/tb_instr_prefetch.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared types and helpers for the instruction prefetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] word;
  } fetch_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prefetch_fifo.sv
// ============================================================================
// Module : prefetch_fifo
// Brief  : DEPTH-entry synchronous FIFO of {pc, word} entries; flush beats push.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prefetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int IDX_W   = clog2(DEPTH),
  localparam int PTR_W   = IDX_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           din,
  output entry_t           head,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             push_ok;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == PTR_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_ok)       wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop && !empty) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem_q[wr_ptr_q[IDX_W-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/instr_prefetch.sv
// ============================================================================
// Module : instr_prefetch
// Brief  : Sequential instruction prefetcher between CPU fetch stage and bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_prefetch
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = 4,
  parameter int ADDR_SHIFT = 2,
  parameter int PC_STEP    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] q,
  input  logic              clear,
  input  logic              hold,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data,
  output logic              bus_we,
  output logic              bus_start,
  input  logic [DATA_W-1:0] bus_q,
  input  logic              bus_done
);

  localparam int PTR_W = clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] word;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              outstanding_q, outstanding_d;
  logic              discard_q, discard_d;
  logic              need_sync_q, need_sync_d;

  logic              redirect, issue, push, pop, done_valid;
  entry_t            head, push_entry;
  logic [PTR_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  prefetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (push_entry),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    hit = !clear && !need_sync_q && !fifo_empty && (head.pc == addr);
    q   = hit ? head.word : '0;
  end

  // Any mismatch between the CPU's PC and the buffered stream resyncs to addr;
  // a stalled CPU is never redirected so its head stays put.
  always_comb begin
    redirect   = clear || need_sync_q ||
                 ((fifo_count != '0) && (head.pc != addr) && !hold);
    pop        = hit && !hold;
    done_valid = bus_done && outstanding_q;
    push       = done_valid && !discard_q && !redirect;
    // Issue waits out a redirect so it always uses the resynced fetch_pc.
    issue      = !outstanding_q && !fifo_full && !redirect;
    push_entry = '{pc: fetch_pc_q, word: bus_q};
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    bus_addr_d    = bus_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    need_sync_d   = need_sync_q;

    if (done_valid) begin
      outstanding_d = 1'b0;
      discard_d     = 1'b0;
      if (push) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    if (issue) begin
      outstanding_d = 1'b1;
      bus_addr_d    = fetch_pc_q >> ADDR_SHIFT;
    end

    // An in-flight read cannot be cancelled on the bus, so its data is tagged stale.
    if (redirect) begin
      fetch_pc_d  = addr;
      need_sync_d = 1'b0;
      if (outstanding_q && !bus_done) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= '0;
      bus_addr_q    <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      need_sync_q   <= 1'b1;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      bus_addr_q    <= bus_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      need_sync_q   <= need_sync_d;
    end
  end

  assign bus_start = outstanding_q;
  assign bus_addr  = bus_addr_q;
  assign bus_data  = '0;
  assign bus_we    = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch.sv
// ============================================================================
// Module : tb_instr_prefetch
// Brief  : Scoreboard bench for instr_prefetch with a latency-configurable bus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_prefetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        hit;
  logic [31:0] q;
  logic        clear, hold;
  logic [31:0] bus_addr, bus_data;
  logic        bus_we, bus_start;
  logic [31:0] bus_q;
  logic        bus_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_prefetch #(
    .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .ADDR_SHIFT(2), .PC_STEP(4)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .hit(hit), .q(q),
    .clear(clear), .hold(hold),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_we(bus_we),
    .bus_start(bus_start), .bus_q(bus_q), .bus_done(bus_done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] wa);
    return {wa[15:0] ^ 16'h5A3C, ~wa[15:0]};
  endfunction

  // Bus slave: completes bus_lat cycles after bus_start rises.
  int bus_lat = 2;
  int lat_cnt = 0;
  initial begin
    bus_done = 1'b0;
    bus_q    = '0;
    forever begin
      @(posedge clk); #1;
      bus_done = 1'b0;
      bus_q    = '0;
      if (reset !== 1'b1 || !bus_start) lat_cnt = 0;
      else begin
        lat_cnt++;
        if (lat_cnt >= bus_lat) begin
          bus_done = 1'b1;
          bus_q    = mem_word(bus_addr);
          lat_cnt  = 0;
        end
      end
    end
  end

  // Issue monitor: expected word-address sequence and FIFO occupancy model.
  logic [31:0] exp_issue  = '0;
  logic [31:0] start_addr = '0;
  logic        prev_start = 1'b0;
  bit          occ_en     = 1'b0;
  int          occ        = 0;
  initial forever begin
    @(negedge clk);
    if (bus_start && !prev_start) begin
      check("issue_addr", bus_addr, exp_issue);
      exp_issue  = exp_issue + 32'd1;
      start_addr = bus_addr;
    end else if (bus_start) begin
      check("bus_addr_stable", bus_addr, start_addr);
    end
    prev_start = bus_start;
    if (occ_en) begin
      if (occ == DEPTH) check("no_issue_when_full", bus_start, 0);
      occ = occ + (bus_done ? 1 : 0) - ((hit && !hold) ? 1 : 0);
    end
  end

  // CPU model and consumption scoreboard.
  logic [31:0] cpu_pc;
  bit          cpu_hold, cpu_clear;
  logic [31:0] exp_q[$];
  int          consumed;
  bit          arm_cod, cod_fired;
  logic [31:0] cod_pc;

  task automatic redirect_to(input logic [31:0] pc);
    cpu_pc = pc;
    exp_q.delete();
    exp_q.push_back(mem_word(pc >> 2));
  endtask

  task automatic cycle();
    @(posedge clk); #2;
    if (arm_cod && bus_done) begin
      arm_cod   = 1'b0;
      cod_fired = 1'b1;
      cpu_clear = 1'b1;
      redirect_to(cod_pc);
    end
    addr  = cpu_pc;
    hold  = cpu_hold;
    clear = cpu_clear;
    @(negedge clk); #1;
    if (hit) begin
      check("q_on_hit", q, exp_q[0]);
      if (!hold) begin
        void'(exp_q.pop_front());
        cpu_pc = cpu_pc + 32'd4;
        exp_q.push_back(mem_word(cpu_pc >> 2));
        consumed++;
      end
    end else begin
      check("q_zero_on_miss", q, 0);
    end
    cpu_clear = 1'b0;
  endtask

  task automatic run_until_consumed(input int n, input string tag);
    int target, budget;
    target = consumed + n;
    budget = 200;
    while (consumed < target && budget > 0) begin
      cycle();
      budget--;
    end
    check(tag, consumed >= target, 1);
  endtask

  task automatic wait_issue(input string tag, output logic [31:0] a);
    int  budget;
    bit  seen;
    logic p;
    budget = 50;
    seen   = 1'b0;
    while (!seen && budget > 0) begin
      p = bus_start;
      cycle();
      if (bus_start && !p) seen = 1'b1;
      budget--;
    end
    check(tag, seen, 1);
    a = bus_addr;
  endtask

  initial begin
    logic [31:0] x;
    int g;
    reset = 1'b0; addr = '0; clear = 1'b0; hold = 1'b0;
    cpu_pc = '0; cpu_hold = 1'b0; cpu_clear = 1'b0; consumed = 0;
    arm_cod = 1'b0; cod_fired = 1'b0; cod_pc = '0;
    redirect_to(32'h0);

    repeat (3) cycle();
    check("rst_hit", hit, 0);
    check("rst_q", q, 0);
    check("rst_bus_start", bus_start, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("tied_we_data", {bus_we, bus_data}, 0);

    // Cold start and streaming
    exp_issue = 32'h0;
    occ = 0;
    occ_en = 1'b1;
    @(posedge clk); #3; reset = 1'b1;
    run_until_consumed(6, "stream_progress");

    // Hold: FIFO fills, head stays, no issue while full
    cpu_hold = 1'b1;
    repeat (20) cycle();
    check("hold_hit", hit, 1);
    check("hold_q", q, mem_word(cpu_pc >> 2));
    check("hold_full_idle", bus_start, 0);
    cpu_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      check("drain_zero_wait", hit, 1);
    end
    run_until_consumed(4, "stream_after_hold");
    occ_en = 1'b0;

    // Clear while a slow transaction is outstanding
    bus_lat = 4;
    wait_issue("mt_issue_seen", x);
    cpu_clear = 1'b1;
    redirect_to(32'h100);
    cycle();
    exp_issue = 32'h40;
    check("mt_start_held", bus_start, 1);
    g = 0;
    while (bus_start && g < 20) begin
      check("mt_held_addr", bus_addr, x);
      check("mt_no_hit", hit, 0);
      cycle();
      g++;
    end
    check("mt_done_seen", bus_start, 0);
    bus_lat = 2;
    run_until_consumed(3, "mt_refetch");

    // Clear coincident with bus_done
    cod_pc  = 32'h200;
    arm_cod = 1'b1;
    g = 0;
    while (!cod_fired && g < 50) begin
      cycle();
      g++;
    end
    check("cod_fired", cod_fired, 1);
    exp_issue = 32'h80;
    cycle();
    check("cod_no_stale_hit", hit, 0);
    run_until_consumed(2, "cod_refetch");

    // Implicit redirect: head pc 0x08, CPU jumps to 0x20
    cpu_clear = 1'b1;
    redirect_to(32'h0);
    cycle();
    exp_issue = 32'h0;
    run_until_consumed(2, "ir_pre");
    cpu_hold = 1'b1;
    g = 0;
    do begin
      cycle();
      g++;
    end while (!hit && g < 30);
    check("ir_head8_hit", hit, 1);
    cpu_hold = 1'b0;
    redirect_to(32'h20);
    cycle();
    check("ir_no_hit", hit, 0);
    exp_issue = 32'h08;
    run_until_consumed(2, "ir_refetch");

    // Asynchronous reset mid-transaction
    wait_issue("rm_issue_seen", x);
    @(posedge clk); #3; reset = 1'b0;
    #1;
    check("rm_bus_start", bus_start, 0);
    check("rm_hit", hit, 0);
    check("rm_q", q, 0);
    redirect_to(32'h300);
    exp_issue = 32'hC0;
    repeat (2) cycle();
    check("rm_bus_addr", bus_addr, 0);
    @(posedge clk); #3; reset = 1'b1;
    run_until_consumed(3, "rm_restart");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
